// File: rtl/pool_pkg.sv
// Shared types and width helpers for the streaming K x K pooling block.
package pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   // A K x K sum of W-bit samples needs 2*log2(K) extra bits to stay exact.
   function automatic int acc_width(input int w, input int k);
      return w + 2 * $clog2(k);
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/stream_pool_if.sv
// Pixel-in / pooled-pixel-out valid-ready handshake bundle for stream_pool.
interface stream_pool_if #(
   parameter int DW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/pool_combine.sv
// One channel of one accumulator entry: load, max-merge or add a sample,
// and present the finished window value for the current mode.
module pool_combine
   import pool_pkg::*;
#(
   parameter int W = 8,
   parameter int K = 2
) (
   input  pool_mode_e                   mode,
   input  logic                         load,
   input  logic [acc_width(W, K)-1:0]   acc_i,
   input  logic [W-1:0]                 sample_i,
   output logic [acc_width(W, K)-1:0]   acc_o,
   output logic [W-1:0]                 result_o
);
   localparam int AW = acc_width(W, K);
   localparam int SH = 2 * $clog2(K);

   logic [AW-1:0] sample_ext;

   // NOTE: every branch assigns acc_o, so this stays combinational with no latch.
   always_comb begin
      sample_ext = AW'(sample_i);
      if (load) begin
         acc_o = sample_ext;
      end else if (mode == POOL_MAX) begin
         acc_o = (acc_i > sample_ext) ? acc_i : sample_ext;
      end else begin
         acc_o = acc_i + sample_ext;
      end
   end

   // Max never exceeds W bits; the average is a plain truncating shift.
   assign result_o = (mode == POOL_AVG) ? W'(acc_o >> SH) : acc_o[W-1:0];

endmodule

// File: rtl/stream_pool.sv
// Streaming K x K max/average pooling over an N x N raster frame of C-channel
// pixels, holding one line of partial window results.
module stream_pool
   import pool_pkg::*;
#(
   parameter int N = 32,
   parameter int K = 2,
   parameter int C = 4,
   parameter int W = 8
) (
   input logic          clk,
   input logic          rst,
   input logic          clear,
   input logic          mode,
   stream_pool_if.slave bus
);
   localparam int LK = $clog2(K);
   localparam int AW = acc_width(W, K);
   localparam int J  = N / K;
   localparam int XW = (N > 1) ? $clog2(N) : 1;
   localparam int JW = (J > 1) ? $clog2(J) : 1;
   localparam logic [XW-1:0] X_MAX = XW'(N - 1);

   if ((N % K) != 0) begin : g_bad_n
      $error("stream_pool: N must be divisible by K");
   end
   if (!is_pow2(K) || (K < 2) || (K > 8)) begin : g_bad_k
      $error("stream_pool: K must be a power of two in 2..8");
   end

   logic [XW-1:0]  x_q, x_d, y_q, y_d;
   pool_mode_e     mode_q, mode_d;
   logic           out_valid_q, out_valid_d;
   logic           out_last_q, out_last_d;
   logic [C*W-1:0] out_data_q, out_data_d;

   logic [AW-1:0]  acc_q [J][C];
   logic [AW-1:0]  acc_rd [C];
   logic [AW-1:0]  acc_d [C];
   logic [W-1:0]   res [C];
   logic [C*W-1:0] pooled;

   logic           in_fire, out_fire;
   logic           frame_start, win_first, win_last;
   pool_mode_e     cur_mode;
   logic [JW-1:0]  col;

   assign bus.in_ready  = !(out_valid_q && !bus.out_ready);
   assign in_fire       = bus.in_valid && bus.in_ready;
   assign out_fire      = out_valid_q && bus.out_ready;

   // The pixel at (0, 0) already pools with the mode being latched alongside it.
   assign frame_start = (x_q == '0) && (y_q == '0);
   assign cur_mode    = frame_start ? pool_mode_e'(mode) : mode_q;
   assign win_first   = (x_q[LK-1:0] == '0) && (y_q[LK-1:0] == '0);
   assign win_last    = (&x_q[LK-1:0]) && (&y_q[LK-1:0]);
   assign col         = JW'(x_q >> LK);

   for (genvar c = 0; c < C; c++) begin : g_ch
      assign acc_rd[c] = acc_q[col][c];

      pool_combine #(
         .W (W),
         .K (K)
      ) u_combine (
         .mode     (cur_mode),
         .load     (win_first),
         .acc_i    (acc_rd[c]),
         .sample_i (bus.in_data[c*W +: W]),
         .acc_o    (acc_d[c]),
         .result_o (res[c])
      );

      assign pooled[c*W +: W] = res[c];
   end

   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;

      if (clear) begin
         x_d         = '0;
         y_d         = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         if (out_fire) begin
            out_valid_d = 1'b0;
         end
         if (in_fire) begin
            mode_d = cur_mode;
            if (x_q == X_MAX) begin
               x_d = '0;
               y_d = (y_q == X_MAX) ? '0 : y_q + 1'b1;
            end else begin
               x_d = x_q + 1'b1;
            end
            // A completing window refills the register in the same cycle it drains.
            if (win_last) begin
               out_valid_d = 1'b1;
               out_data_d  = pooled;
               out_last_d  = (x_q == X_MAX) && (y_q == X_MAX);
            end
         end
      end
   end

   // NOTE: state updates use <= so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q         <= '0;
         y_q         <= '0;
         mode_q      <= POOL_MAX;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   // NOTE: the accumulator line has no reset; each window reloads it on its first pixel.
   always_ff @(posedge clk) begin
      if (in_fire && !clear) begin
         for (int c = 0; c < C; c++) begin
            acc_q[col][c] <= acc_d[c];
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_stream_pool.sv
// Bench for stream_pool: directed 4x4/K=2 frame table plus randomized
// 8x8/K=4/C=4 frames against a window-arithmetic reference model.
module tb_stream_pool;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, clear_a, clear_b, mode_a, mode_b;

   stream_pool_if #(.DW(8))  a_if ();
   stream_pool_if #(.DW(32)) b_if ();

   stream_pool #(.N(4), .K(2), .C(1), .W(8)) dut_a (
      .clk   (clk),
      .rst   (rst_a),
      .clear (clear_a),
      .mode  (mode_a),
      .bus   (a_if.slave)
   );

   stream_pool #(.N(8), .K(4), .C(4), .W(8)) dut_b (
      .clk   (clk),
      .rst   (rst_b),
      .clear (clear_b),
      .mode  (mode_b),
      .bus   (b_if.slave)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- small DUT: directed frame table ----------------
   typedef struct {
      logic            m0;
      int              toggle_at;
      bit              desc;
      int              stall;
      logic [3:0][7:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic m0, input int toggle_at, input bit desc,
                               input int stall, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
      vec_t v;
      v.m0 = m0; v.toggle_at = toggle_at; v.desc = desc; v.stall = stall;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
      return v;
   endfunction

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } out_a_t;

   out_a_t got_a [$];
   vec_t   vecs [8];

   always @(negedge clk) begin
      if (rst_a && a_if.out_valid && a_if.out_ready)
         got_a.push_back({a_if.out_last, a_if.out_data});
   end

   // Inputs only change just after a rising edge, so in_ready at the falling
   // edge is exactly what the next rising edge sees.
   task automatic send_a(input logic [7:0] d, input logic m);
      int   n  = 0;
      logic ok = 1'b0;
      a_if.in_valid = 1'b1;
      a_if.in_data  = d;
      mode_a        = m;
      do begin
         @(negedge clk);
         ok = a_if.in_ready;
         step();
         n++;
      end while (!ok && n < 100);
      check("a_accept_wait", ok, 1'b1);
   endtask

   task automatic send_frame_a(input logic m);
      for (int p = 0; p < 16; p++) send_a(8'(p), m);
      a_if.in_valid = 1'b0;
   endtask

   task automatic expect_a(input string tag, input logic [3:0][7:0] exp);
      int n = 0;
      while (got_a.size() < 4 && n < 50) begin
         step();
         n++;
      end
      check({tag, "_count"}, got_a.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_a.size()) begin
            check($sformatf("%s_data%0d", tag, i), got_a[i].data, exp[i]);
            check($sformatf("%s_last%0d", tag, i), got_a[i].last, (i == 3));
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      got_a.delete();
      a_if.out_ready = (v.stall == 0);
      fork
         begin
            for (int p = 0; p < 16; p++) begin
               logic m;
               m = (v.toggle_at >= 0 && p >= v.toggle_at) ? !v.m0 : v.m0;
               send_a(v.desc ? 8'(15 - p) : 8'(p), m);
            end
            a_if.in_valid = 1'b0;
         end
         begin
            if (v.stall > 0) begin
               int n = 0;
               while (!a_if.out_valid && n < 100) begin
                  step();
                  n++;
               end
               check("stall_wait", n < 100, 1'b1);
               for (int s = 0; s < v.stall; s++) begin
                  check("stall_in_ready", a_if.in_ready, 1'b0);
                  check("stall_out_valid", a_if.out_valid, 1'b1);
                  check("stall_out_data", a_if.out_data, v.exp[0]);
                  step();
               end
               a_if.out_ready = 1'b1;
            end
         end
      join
      expect_a($sformatf("vec%0d", idx), v.exp);
   endtask

   // ---------------- large DUT: randomized frames + model ----------------
   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } out_b_t;

   out_b_t      exp_b [$];
   logic [31:0] pix_b [64];
   logic        b_hold = 1'b0;
   logic [31:0] b_hold_data;
   logic        b_hold_last;

   always @(negedge clk) begin
      if (rst_b) begin
         check("b_in_ready_rule", b_if.in_ready, !(b_if.out_valid && !b_if.out_ready));
         if (b_hold) begin
            check("b_hold_valid", b_if.out_valid, 1'b1);
            check("b_hold_data", b_if.out_data, b_hold_data);
            check("b_hold_last", b_if.out_last, b_hold_last);
         end
         if (b_if.out_valid && b_if.out_ready) begin
            check("b_output_expected", exp_b.size() > 0, 1'b1);
            if (exp_b.size() > 0) begin
               out_b_t e;
               e = exp_b.pop_front();
               check("b_out_data", b_if.out_data, e.data);
               check("b_out_last", b_if.out_last, e.last);
            end
         end
         b_hold      = b_if.out_valid && !b_if.out_ready;
         b_hold_data = b_if.out_data;
         b_hold_last = b_if.out_last;
      end else begin
         b_hold = 1'b0;
      end
   end

   // Each 4x4 window of the 8x8 frame, reduced per channel; windows finish in raster order.
   function automatic void model_push_b(input logic m);
      for (int wy = 0; wy < 2; wy++) begin
         for (int wx = 0; wx < 2; wx++) begin
            logic [31:0] word = '0;
            for (int c = 0; c < 4; c++) begin
               int mx = 0, sum = 0;
               for (int dy = 0; dy < 4; dy++) begin
                  for (int dx = 0; dx < 4; dx++) begin
                     int v;
                     v = int'((pix_b[(wy*4 + dy)*8 + wx*4 + dx] >> (8*c)) & 32'hFF);
                     sum += v;
                     if (v > mx) mx = v;
                  end
               end
               word[8*c +: 8] = m ? 8'(sum / 16) : 8'(mx);
            end
            exp_b.push_back({(wy == 1 && wx == 1), word});
         end
      end
   endfunction

   task automatic send_b(input logic [31:0] d, input logic m);
      int   n  = 0;
      logic ok = 1'b0;
      repeat ($urandom_range(0, 2)) begin
         b_if.in_valid = 1'b0;
         mode_b        = 1'($urandom);
         step();
      end
      b_if.in_valid = 1'b1;
      b_if.in_data  = d;
      mode_b        = m;
      do begin
         @(negedge clk);
         ok = b_if.in_ready;
         step();
         n++;
      end while (!ok && n < 100);
      check("b_accept_wait", ok, 1'b1);
   endtask

   task automatic run_frame_b(input bit all_ones, input logic m);
      bit done = 1'b0;
      for (int p = 0; p < 64; p++) pix_b[p] = all_ones ? 32'hFFFF_FFFF : $urandom;
      if (all_ones) begin
         for (int i = 0; i < 4; i++) exp_b.push_back({(i == 3), 32'hFFFF_FFFF});
      end else begin
         model_push_b(m);
      end
      fork
         begin
            for (int p = 0; p < 64; p++) send_b(pix_b[p], (p == 0) ? m : 1'($urandom));
            b_if.in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               b_if.out_ready = ($urandom_range(0, 3) != 0);
               step();
            end
            b_if.out_ready = 1'b1;
         end
      join
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = mk(1'b0, -1, 1'b0, 0, 8'd5,  8'd7,  8'd13, 8'd15);
      vecs[1] = mk(1'b1, -1, 1'b0, 0, 8'd2,  8'd4,  8'd10, 8'd12);
      vecs[2] = mk(1'b0, -1, 1'b1, 0, 8'd15, 8'd13, 8'd7,  8'd5);
      vecs[3] = mk(1'b1, -1, 1'b1, 3, 8'd12, 8'd10, 8'd4,  8'd2);
      vecs[4] = mk(1'b0, -1, 1'b0, 6, 8'd5,  8'd7,  8'd13, 8'd15);
      vecs[5] = mk(1'b0,  5, 1'b0, 0, 8'd5,  8'd7,  8'd13, 8'd15);
      vecs[6] = mk(1'b1, -1, 1'b0, 0, 8'd2,  8'd4,  8'd10, 8'd12);
      vecs[7] = mk(1'b1,  5, 1'b0, 0, 8'd2,  8'd4,  8'd10, 8'd12);

      rst_a = 1'b0; rst_b = 1'b0;
      clear_a = 1'b0; clear_b = 1'b0;
      mode_a = 1'b0; mode_b = 1'b0;
      a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
      step();
      step();

      check("a_rst_out_valid", a_if.out_valid, 1'b0);
      check("a_rst_out_last",  a_if.out_last,  1'b0);
      check("a_rst_out_data",  a_if.out_data,  '0);
      check("a_rst_in_ready",  a_if.in_ready,  1'b1);
      check("b_rst_out_valid", b_if.out_valid, 1'b0);
      check("b_rst_out_data",  b_if.out_data,  '0);
      check("b_rst_in_ready",  b_if.in_ready,  1'b1);

      rst_a = 1'b1;
      rst_b = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // clear while a pooled pixel is valid and a new pixel is offered
      got_a.delete();
      a_if.out_ready = 1'b1;
      for (int p = 0; p < 6; p++) send_a(8'(p), 1'b0);
      clear_a       = 1'b1;
      a_if.in_valid = 1'b1;
      a_if.in_data  = 8'd99;
      step();
      clear_a       = 1'b0;
      a_if.in_valid = 1'b0;
      check("clear_out_valid", a_if.out_valid, 1'b0);
      check("clear_out_last",  a_if.out_last,  1'b0);
      got_a.delete();
      send_frame_a(1'b0);
      expect_a("after_clear", {8'd15, 8'd13, 8'd7, 8'd5});

      // reset mid-frame after pixel 9
      got_a.delete();
      for (int p = 0; p < 10; p++) send_a(8'(p), 1'b0);
      a_if.in_valid = 1'b0;
      step();
      step();
      check("partial_outputs", got_a.size(), 2);
      rst_a = 1'b0;
      #1;
      check("mid_rst_out_valid", a_if.out_valid, 1'b0);
      check("mid_rst_in_ready",  a_if.in_ready,  1'b1);
      check("mid_rst_out_data",  a_if.out_data,  '0);
      step();
      check("mid_rst_out_valid2", a_if.out_valid, 1'b0);
      rst_a = 1'b1;
      step();
      got_a.delete();
      send_frame_a(1'b0);
      expect_a("after_rst", {8'd15, 8'd13, 8'd7, 8'd5});

      // wide configuration: saturated frames, then random frames with gaps and backpressure
      run_frame_b(1'b1, 1'b1);
      run_frame_b(1'b1, 1'b0);
      for (int f = 0; f < 6; f++) run_frame_b(1'b0, 1'($urandom));
      begin
         int n = 0;
         while (exp_b.size() != 0 && n < 200) begin
            step();
            n++;
         end
      end
      check("b_drain", exp_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
